accum_sequencer: RTL and testbench

Controller that sequences the 16-bit signed load/clear register as an accumulator. It accepts a job of N signed operands through a valid/ready stream and clears the register once at job start. It adds each accepted operand to the register's current value with saturation, and drives the register's clear/load controls and data. It signals completion and sticky overflow to the surrounding control logic.

---
 rtl/accum_sequencer.sv | 102 ++++++++++
 tb/tb_accum_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/accum_sequencer.sv
// Job sequencer that drives an external load/clear register as a saturating
// accumulator: one CLEAR per job, then one saturated add per accepted operand.
module accum_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic [WIDTH-1:0] acc_q,
    output logic             reg_clr,
    output logic             reg_ld,
    output logic [WIDTH-1:0] reg_d,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_ACCUM = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           r_state;
    logic [CNT_W-1:0] r_remaining;
    logic             r_ovf;

    logic [WIDTH:0]   w_sum;
    logic             w_pos_sat;
    logic             w_neg_sat;
    logic             w_sat;
    logic [WIDTH-1:0] w_sat_sum;
    logic             w_in_accum;
    logic             w_accept;

    // One guard bit is enough: the two top bits disagree exactly on overflow.
    assign w_sum     = {acc_q[WIDTH-1], acc_q} + {in_data[WIDTH-1], in_data};
    assign w_pos_sat = ~w_sum[WIDTH] &  w_sum[WIDTH-1];
    assign w_neg_sat =  w_sum[WIDTH] & ~w_sum[WIDTH-1];
    assign w_sat     = w_pos_sat | w_neg_sat;
    assign w_sat_sum = w_pos_sat ? MAX_POS :
                       w_neg_sat ? MAX_NEG : w_sum[WIDTH-1:0];

    // Control outputs decode straight from the state flop so an async reset
    // drops them immediately, without waiting for an edge.
    assign w_in_accum = (r_state == S_ACCUM);
    assign w_accept   = w_in_accum & in_valid;

    assign in_ready = w_in_accum;
    assign reg_clr  = (r_state == S_CLEAR);
    assign reg_ld   = w_accept;
    assign reg_d    = w_in_accum ? w_sat_sum : '0;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign ovf      = r_ovf;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_CLEAR;
                        r_remaining <= count;
                        r_ovf       <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    r_state <= (r_remaining != '0) ? S_ACCUM : S_DONE;
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_remaining <= r_remaining - CNT_W'(1);
                        if (w_sat)
                            r_ovf <= 1'b1;
                        if (r_remaining == CNT_W'(1))
                            r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum_sequencer.sv
// Randomized bench for accum_sequencer: models the external register and checks
// every cycle of each job against a plain-arithmetic saturating-sum model.
module tb_accum_sequencer;

    localparam int W  = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] count = '0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic [W-1:0]  acc_q;
    logic          reg_clr;
    logic          reg_ld;
    logic [W-1:0]  reg_d;
    logic          busy;
    logic          done;
    logic          ovf;

    always #5 clk = ~clk;

    accum_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .clr(clr), .start(start), .count(count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .acc_q(acc_q), .reg_clr(reg_clr), .reg_ld(reg_ld), .reg_d(reg_d),
        .busy(busy), .done(done), .ovf(ovf)
    );

    // External load/clear register; starts with junk so CLEAR is exercised.
    logic [W-1:0] ext_reg = 16'h1234;
    always @(posedge clk) begin
        if (reg_clr)     ext_reg <= '0;
        else if (reg_ld) ext_reg <= reg_d;
    end
    assign acc_q = ext_reg;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int sat_add(input int a, input int b);
        int s;
        s = a + b;
        if (s > 32767)  return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int  ops[$];
    int  m_sum;
    bit  m_ovf;

    // Runs one job with operands from ops[]; gap cycles of in_valid=0 precede
    // each beat, and start may be poked during gaps and DONE to prove it's ignored.
    task automatic run_job(input int n, input int min_gap, input int max_gap, input bit poke);
        int g;
        start = 1'b1; count = CW'(n); in_valid = 1'b0;
        #1;
        chk("idle_busy", int'(busy), 0);
        chk("idle_ready", int'(in_ready), 0);
        step();
        start = 1'b0;
        m_sum = 0; m_ovf = 1'b0;
        #1;
        chk("clear_regclr", int'(reg_clr), 1);
        chk("clear_regld", int'(reg_ld), 0);
        chk("clear_busy", int'(busy), 1);
        chk("clear_ready", int'(in_ready), 0);
        chk("clear_ovf", int'(ovf), 0);
        chk("clear_regd", int'(reg_d), 0);
        step();
        for (int i = 0; i < n; i++) begin
            g = $urandom_range(max_gap, min_gap);
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
                start    = poke & $urandom_range(1, 0);
                #1;
                chk("gap_ready", int'(in_ready), 1);
                chk("gap_regld", int'(reg_ld), 0);
                chk("gap_regclr", int'(reg_clr), 0);
                chk("gap_done", int'(done), 0);
                chk("gap_ovf", int'(ovf), int'(m_ovf));
                chk("gap_regd", int'($signed(reg_d)), sat_add(m_sum, int'($signed(in_data))));
                step();
            end
            in_valid = 1'b1;
            in_data  = W'(ops[i]);
            start    = 1'b0;
            #1;
            chk("beat_ready", int'(in_ready), 1);
            chk("beat_regld", int'(reg_ld), 1);
            chk("beat_regclr", int'(reg_clr), 0);
            chk("beat_regd", int'($signed(reg_d)), sat_add(m_sum, ops[i]));
            chk("beat_acc", int'($signed(acc_q)), m_sum);
            if (m_sum + ops[i] > 32767 || m_sum + ops[i] < -32768) m_ovf = 1'b1;
            m_sum = sat_add(m_sum, ops[i]);
            step();
        end
        in_valid = 1'b0;
        start    = poke;
        #1;
        chk("done_pulse", int'(done), 1);
        chk("done_busy", int'(busy), 1);
        chk("done_ready", int'(in_ready), 0);
        chk("done_regld", int'(reg_ld), 0);
        chk("done_acc", int'($signed(acc_q)), m_sum);
        chk("done_ovf", int'(ovf), int'(m_ovf));
        step();
        start = 1'b0;
        #1;
        chk("post_done", int'(done), 0);
        chk("post_busy", int'(busy), 0);
        chk("post_ovf", int'(ovf), int'(m_ovf));
        chk("post_acc", int'($signed(acc_q)), m_sum);
    endtask

    initial begin
        int n;
        #2;
        chk("rst_ready", int'(in_ready), 0);
        chk("rst_regclr", int'(reg_clr), 0);
        chk("rst_regld", int'(reg_ld), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ovf", int'(ovf), 0);
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        step();

        ops = '{100, -50, 7};       run_job(3, 0, 0, 1'b0);
        chk("plan1_sum", int'($signed(acc_q)), 57);
        ops = '{30000, 10000};      run_job(2, 0, 0, 1'b0);
        chk("plan2_ovf", int'(ovf), 1);
        ops = '{-32768, -1};        run_job(2, 0, 0, 1'b1);
        chk("plan3_sum", int'($signed(acc_q)), -32768);
        ops = '{5};                 run_job(1, 0, 0, 1'b0);
        chk("plan3b_sum", int'($signed(acc_q)), 5);
        ops = '{1234, -4321};       run_job(2, 3, 3, 1'b1);
        ops = '{};                  run_job(0, 0, 0, 1'b0);
        chk("zero_sum", int'($signed(acc_q)), 0);

        // Abandon a job with an async reset after one beat of three.
        start = 1'b1; count = CW'(3);
        step();
        start = 1'b0;
        step();
        in_valid = 1'b1; in_data = W'(11);
        step();
        in_data = W'(22);
        #1;
        chk("pre_rst_regld", int'(reg_ld), 1);
        clr = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ready", int'(in_ready), 0);
        chk("midrst_regld", int'(reg_ld), 0);
        chk("midrst_ovf", int'(ovf), 0);
        #2 clr = 1'b0;
        in_valid = 1'b0;
        step();
        ops = '{9};                 run_job(1, 0, 0, 1'b0);
        chk("after_rst_sum", int'($signed(acc_q)), 9);

        for (int j = 0; j < 40; j++) begin
            n = $urandom_range(15, 0);
            ops = '{};
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(3, 0))
                    0: ops.push_back(int'($signed(W'($urandom))));
                    1: ops.push_back(int'($urandom_range(32767, 20000)));
                    2: ops.push_back(-int'($urandom_range(32768, 20000)));
                    default: ops.push_back(int'($urandom_range(200, 0)) - 100);
                endcase
            end
            run_job(n, 0, 2, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
